tlk2711_rx_checker: RTL and testbench

Receive-side framer and checker for the TLK2711 SERDES link. It consumes the 16-bit parallel receive bus and the K-flags. It hunts for the comma/SOF preamble produced by the TLK2711 transmit block in normal mode, then checks each payload word against the expected counting pattern. It reports frame status, lock and error statistics to software/ILA, and sits beside the transmit block on the same `clk` domain.

---
 rtl/tlk2711_rx_checker.sv | 150 +++++++++++++++
 tb/tb_tlk2711_rx_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_rx_checker.sv
// rtl/tlk2711_rx_checker.sv - TLK2711 receive framer and counting-pattern checker
module tlk2711_rx_checker #(
  parameter int DATA_LEN    = 32,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  input  logic [15:0] i_rxd,
  output logic [15:0] o_data,
  output logic        o_data_valid,
  output logic        o_locked,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_err_frame_cnt,
  output logic [15:0] o_word_err_cnt
);

  localparam logic [1:0] IDLE_s  = 2'd0;
  localparam logic [1:0] HUNT_s  = 2'd1;
  localparam logic [1:0] COMMA_s = 2'd2;
  localparam logic [1:0] DATA_s  = 2'd3;

  localparam logic [7:0] LAST_K   = 8'(DATA_LEN - 1);
  localparam logic [3:0] LOCK_RUN = 4'(LOCK_FRAMES);

  logic [1:0] state;
  logic [7:0] k;
  logic       frame_bad;
  logic [3:0] run;

  logic is_comma, is_sof, is_data, is_other;
  logic in_data, mismatch, word_err_ev, abort_ev, complete, good_ev, bad_ev;
  logic [3:0] run_inc;

  always_comb begin
    is_comma    = i_rkmsb && !i_rklsb && (i_rxd == 16'hBCC5);
    is_sof      = i_rkmsb && !i_rklsb && (i_rxd == 16'hBCAB);
    is_data     = !i_rkmsb && !i_rklsb;
    is_other    = !is_comma && !is_sof && !is_data;
    in_data     = i_enable && (state == DATA_s);
    mismatch    = is_data && (i_rxd != {k, k});
    word_err_ev = in_data && (is_other || mismatch);
    abort_ev    = in_data && (is_comma || is_sof);
    // Abort has priority over completion when a comma lands on the last index.
    complete    = in_data && (is_data || is_other) && (k == LAST_K);
    good_ev     = complete && !(frame_bad || word_err_ev);
    bad_ev      = abort_ev || (complete && (frame_bad || word_err_ev));
    run_inc     = (run >= LOCK_RUN) ? LOCK_RUN : run + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE_s;
      k               <= 8'd0;
      frame_bad       <= 1'b0;
      run             <= 4'd0;
      o_data          <= 16'd0;
      o_data_valid    <= 1'b0;
      o_locked        <= 1'b0;
      o_frame_done    <= 1'b0;
      o_frame_err     <= 1'b0;
      o_frame_cnt     <= 32'd0;
      o_err_frame_cnt <= 16'd0;
      o_word_err_cnt  <= 16'd0;
    end else begin
      o_frame_done <= good_ev;
      o_frame_err  <= bad_ev;
      o_data_valid <= 1'b0;

      if (i_clear) begin
        o_frame_cnt     <= 32'd0;
        o_err_frame_cnt <= 16'd0;
        o_word_err_cnt  <= 16'd0;
      end else begin
        if (good_ev)
          o_frame_cnt <= o_frame_cnt + 32'd1;
        if (bad_ev && o_err_frame_cnt != 16'hFFFF)
          o_err_frame_cnt <= o_err_frame_cnt + 16'd1;
        if (word_err_ev && o_word_err_cnt != 16'hFFFF)
          o_word_err_cnt <= o_word_err_cnt + 16'd1;
      end

      if (!i_enable) begin
        state    <= IDLE_s;
        o_locked <= 1'b0;
        run      <= 4'd0;
      end else begin
        case (state)
          IDLE_s: begin
            o_locked <= 1'b0;
            run      <= 4'd0;
            state    <= HUNT_s;
          end
          HUNT_s: begin
            if (is_comma)
              state <= COMMA_s;
          end
          COMMA_s: begin
            if (is_sof) begin
              state     <= DATA_s;
              k         <= 8'd0;
              frame_bad <= 1'b0;
            end else if (!is_comma) begin
              state    <= HUNT_s;
              o_locked <= 1'b0;
            end
          end
          default: begin
            if (abort_ev) begin
              o_locked <= 1'b0;
              run      <= 4'd0;
              if (is_comma) begin
                state <= COMMA_s;
              end else begin
                state     <= DATA_s;
                k         <= 8'd0;
                frame_bad <= 1'b0;
              end
            end else begin
              if (is_data) begin
                o_data_valid <= 1'b1;
                o_data       <= i_rxd;
              end
              if (word_err_ev)
                frame_bad <= 1'b1;
              k <= k + 8'd1;
              if (complete) begin
                state <= HUNT_s;
                if (good_ev) begin
                  run <= run_inc;
                  if (run_inc == LOCK_RUN)
                    o_locked <= 1'b1;
                end else begin
                  run      <= 4'd0;
                  o_locked <= 1'b0;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// tb/tb_tlk2711_rx_checker.sv - directed table and sequence bench for tlk2711_rx_checker
module tb_tlk2711_rx_checker;

  logic        clk = 1'b0;
  logic        rst, i_enable, i_clear, i_rkmsb, i_rklsb;
  logic [15:0] i_rxd;
  logic [15:0] o_data;
  logic        o_data_valid, o_locked, o_frame_done, o_frame_err;
  logic [31:0] o_frame_cnt;
  logic [15:0] o_err_frame_cnt, o_word_err_cnt;

  int errors = 0;
  int checks = 0;

  tlk2711_rx_checker #(.DATA_LEN(32), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_clear(i_clear),
    .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb), .i_rxd(i_rxd),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_locked(o_locked),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
    .o_frame_cnt(o_frame_cnt), .o_err_frame_cnt(o_err_frame_cnt),
    .o_word_err_cnt(o_word_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, clr, rkm, rkl;
    logic [15:0] rxd;
    logic        v;
    logic [15:0] d;
    logic        done, err, lk;
    logic [15:0] werr, ef;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rkm, input logic rkl, input logic [15:0] rxd);
    i_rkmsb = rkm;
    i_rklsb = rkl;
    i_rxd   = rxd;
    tick();
  endtask

  task automatic send_frame(input int ncomma, input int bad_k, input logic [15:0] bad_val,
                            input logic exp_good, input logic exp_lock);
    logic [7:0]  kb;
    logic [15:0] w;
    for (int c = 0; c < ncomma; c++) begin
      send(1'b1, 1'b0, 16'hBCC5);
      chk("comma_valid", o_data_valid, 1'b0);
    end
    send(1'b1, 1'b0, 16'hBCAB);
    chk("sof_valid", o_data_valid, 1'b0);
    for (int k = 0; k < 32; k++) begin
      kb = 8'(k);
      w  = (k == bad_k) ? bad_val : {kb, kb};
      send(1'b0, 1'b0, w);
      chk("word_valid", o_data_valid, 1'b1);
      chk("word_data", o_data, w);
      if (k < 31) begin
        chk("mid_pulses", {o_frame_done, o_frame_err}, 2'b00);
      end else begin
        chk("end_done", o_frame_done, exp_good);
        chk("end_err", o_frame_err, !exp_good);
        chk("end_locked", o_locked, exp_lock);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, o_data, 16'h0);
    chk({tag, "_valid"}, o_data_valid, 1'b0);
    chk({tag, "_locked"}, o_locked, 1'b0);
    chk({tag, "_done"}, o_frame_done, 1'b0);
    chk({tag, "_err"}, o_frame_err, 1'b0);
    chk({tag, "_fcnt"}, o_frame_cnt, 32'h0);
    chk({tag, "_efcnt"}, o_err_frame_cnt, 16'h0);
    chk({tag, "_wecnt"}, o_word_err_cnt, 16'h0);
  endtask

  initial begin
    //          en    clr   rkm   rkl   rxd       v     d         done  err   lk    werr ef
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hBCC5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBCC5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBCC5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBCC5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBCAB, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0202, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBCAB, 1'b0, 16'h0101, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};

    rst = 1'b1; i_enable = 1'b0; i_clear = 1'b0;
    i_rkmsb = 1'b0; i_rklsb = 1'b0; i_rxd = 16'h0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Missing SOF, OTHER word, SOF abort, enable drop and clear.
    for (int i = 0; i < 14; i++) begin
      i_enable = tbl[i].en;
      i_clear  = tbl[i].clr;
      send(tbl[i].rkm, tbl[i].rkl, tbl[i].rxd);
      chk($sformatf("tbl%0d_valid", i), o_data_valid, tbl[i].v);
      chk($sformatf("tbl%0d_data", i), o_data, tbl[i].d);
      chk($sformatf("tbl%0d_done", i), o_frame_done, tbl[i].done);
      chk($sformatf("tbl%0d_err", i), o_frame_err, tbl[i].err);
      chk($sformatf("tbl%0d_locked", i), o_locked, tbl[i].lk);
      chk($sformatf("tbl%0d_wecnt", i), o_word_err_cnt, tbl[i].werr);
      chk($sformatf("tbl%0d_efcnt", i), o_err_frame_cnt, tbl[i].ef);
    end
    i_clear  = 1'b0;
    i_enable = 1'b1;
    send(1'b0, 1'b0, 16'h0000);

    // Ten clean back-to-back frames; lock after the second.
    for (int f = 0; f < 10; f++)
      send_frame(2, -1, 16'h0, 1'b1, f >= 1);
    chk("clean_fcnt", o_frame_cnt, 32'd10);
    chk("clean_efcnt", o_err_frame_cnt, 16'd0);
    chk("clean_wecnt", o_word_err_cnt, 16'd0);

    // Corrupt word 7 of the third frame, relock after two more.
    send_frame(2, -1, 16'h0, 1'b1, 1'b1);
    send_frame(2, -1, 16'h0, 1'b1, 1'b1);
    send_frame(2, 7, 16'h0708, 1'b0, 1'b0);
    send_frame(2, -1, 16'h0, 1'b1, 1'b0);
    send_frame(2, -1, 16'h0, 1'b1, 1'b1);
    chk("bad_wecnt", o_word_err_cnt, 16'd1);
    chk("bad_efcnt", o_err_frame_cnt, 16'd1);
    chk("bad_fcnt", o_frame_cnt, 32'd14);

    // Comma injected at k=12 aborts; the frame from that comma is checked normally.
    send(1'b1, 1'b0, 16'hBCC5);
    send(1'b1, 1'b0, 16'hBCC5);
    send(1'b1, 1'b0, 16'hBCAB);
    for (int k = 0; k < 12; k++)
      send(1'b0, 1'b0, {8'(k), 8'(k)});
    send(1'b1, 1'b0, 16'hBCC5);
    chk("abort_err", o_frame_err, 1'b1);
    chk("abort_done", o_frame_done, 1'b0);
    chk("abort_valid", o_data_valid, 1'b0);
    chk("abort_locked", o_locked, 1'b0);
    chk("abort_efcnt", o_err_frame_cnt, 16'd2);
    send_frame(0, -1, 16'h0, 1'b1, 1'b0);
    chk("abort_next_fcnt", o_frame_cnt, 32'd15);

    // Reset at k=20, then a clean frame is counted good.
    send(1'b1, 1'b0, 16'hBCC5);
    send(1'b1, 1'b0, 16'hBCC5);
    send(1'b1, 1'b0, 16'hBCAB);
    for (int k = 0; k < 20; k++)
      send(1'b0, 1'b0, {8'(k), 8'(k)});
    rst = 1'b1;
    send(1'b0, 1'b0, 16'h1414);
    check_reset_outputs("midrst");
    rst = 1'b0;
    send(1'b0, 1'b0, 16'h0000);
    send_frame(2, -1, 16'h0, 1'b1, 1'b0);
    chk("postrst_fcnt", o_frame_cnt, 32'd1);
    chk("postrst_efcnt", o_err_frame_cnt, 16'd0);

    // Back-to-back SOF aborts saturate the bad-frame counter.
    send(1'b1, 1'b0, 16'hBCC5);
    send(1'b1, 1'b0, 16'hBCAB);
    for (int i = 0; i < 65540; i++)
      send(1'b1, 1'b0, 16'hBCAB);
    chk("sat_efcnt", o_err_frame_cnt, 16'hFFFF);
    chk("sat_err", o_frame_err, 1'b1);
    chk("sat_done", o_frame_done, 1'b0);
    i_clear = 1'b1;
    send(1'b1, 1'b0, 16'hBCAB);
    chk("clr_efcnt", o_err_frame_cnt, 16'd0);
    chk("clr_fcnt", o_frame_cnt, 32'd0);
    chk("clr_wecnt", o_word_err_cnt, 16'd0);
    i_clear = 1'b0;
    send(1'b1, 1'b0, 16'hBCAB);
    chk("after_clr_efcnt", o_err_frame_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
